// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer for the IF stage.
// Owns the fetch PC, drives the combinational ROM address, captures
// {pc, instr} into a small prefetch FIFO and presents the head to IF/ID
// through a valid/ready handshake. Redirects flush the FIFO, halt_req
// stops new fetches while letting the queue drain.
// Optional build macro FETCH_PERF_EN: enables the saturating
// perf_fetched / perf_flushed counters (tied to 0 otherwise).
module imem_fetch_ctrl #(
  parameter int          DEPTH_BYTES = 1024,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        redirect_misaligned,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] ADDR_MASK = 32'(DEPTH_BYTES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0]   pc, pc_nxt;
  logic [PW-1:0] wr_ptr, wr_nxt;
  logic [PW-1:0] rd_ptr, rd_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;

  logic [31:0] fifo_instr [FIFO_DEPTH];
  logic [31:0] fifo_pc    [FIFO_DEPTH];

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_instr = fifo_instr[rd_ptr];
  assign out_pc    = fifo_pc[rd_ptr];

  // A redirect cancels both the handshake bookkeeping and the fetch of the
  // stale pc; a pop frees a slot so a full queue still streams 1 instr/cycle.
  assign pop  = out_valid && out_ready;
  assign push = !redirect_valid && !halt_req && ((count < FULL_CNT) || pop);

  // Next-state for pc, pointers and occupancy; redirect overrides everything.
  always_comb begin
    pc_nxt    = pc;
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    count_nxt = count;
    if (redirect_valid) begin
      pc_nxt    = {redirect_pc[31:2], 2'b00} & ADDR_MASK;
      wr_nxt    = '0;
      rd_nxt    = '0;
      count_nxt = '0;
    end else begin
      if (push) begin
        pc_nxt = (pc + 32'd4) & ADDR_MASK;
        wr_nxt = wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_nxt = rd_ptr + PW'(1);
      end
      count_nxt = count + CW'(push) - CW'(pop);
    end
  end

  // Control state registers; halted reflects the end-of-cycle occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc                  <= RESET_PC;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      halted              <= 1'b0;
      redirect_misaligned <= 1'b0;
    end else begin
      pc     <= pc_nxt;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      halted <= halt_req && (count_nxt == '0);
      if (redirect_valid) begin
        redirect_misaligned <= |redirect_pc[1:0];
      end
    end
  end

  // Prefetch storage; entries are cleared on reset so an empty head reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr[wr_ptr] <= imem_instr;
      fifo_pc[wr_ptr]    <= pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [CW-1:0] discard_cnt;
  logic [32:0]   flushed_sum;

  // Entries thrown away by a redirect; a same-cycle pop counts as consumed.
  assign discard_cnt = count - CW'(pop);
  assign flushed_sum = {1'b0, perf_flushed} + 33'(discard_cnt);

  // Saturating fetch / flush counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect_valid) begin
        perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
      end
    end
  end
`else
  assign perf_fetched = '0;
  assign perf_flushed = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a vector table covers streaming,
// back-pressure, redirects (aligned, misaligned, wrap) and halt; hand
// sequences cover asynchronous reset mid-stream and the perf counters.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        redirect_misaligned;
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;

  int checks = 0;
  int errors = 0;

  imem_fetch_ctrl #(
    .DEPTH_BYTES(1024),
    .RESET_PC(32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt_req(halt_req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .halted(halted),
    .redirect_misaligned(redirect_misaligned),
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   rom = 32'h0000_0013;
      32'h4:   rom = 32'h0010_0093;
      32'h8:   rom = 32'h0020_0113;
      default: rom = 32'hC0DE_0000 | a;
    endcase
  endfunction

  always_comb imem_instr = rom(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        halt;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        eh;
    logic        em;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic halt,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] eaddr, input logic eh, input logic em);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.halt = halt; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.eh = eh; v.em = em;
    return v;
  endfunction

  initial begin
    //                rv  rpc          hlt  rdy  ev  epc          eaddr        eh  em
    vecs[0]  = mk(0, 32'h0,       0,  1,   1,  32'h000,     32'h004,     0,  0);
    vecs[1]  = mk(0, 32'h0,       0,  1,   1,  32'h004,     32'h008,     0,  0);
    vecs[2]  = mk(0, 32'h0,       0,  1,   1,  32'h008,     32'h00C,     0,  0);
    vecs[3]  = mk(0, 32'h0,       0,  0,   1,  32'h008,     32'h010,     0,  0);
    vecs[4]  = mk(0, 32'h0,       0,  0,   1,  32'h008,     32'h010,     0,  0);
    vecs[5]  = mk(0, 32'h0,       0,  0,   1,  32'h008,     32'h010,     0,  0);
    vecs[6]  = mk(0, 32'h0,       0,  1,   1,  32'h00C,     32'h014,     0,  0);
    vecs[7]  = mk(0, 32'h0,       0,  1,   1,  32'h010,     32'h018,     0,  0);
    vecs[8]  = mk(1, 32'h40,      0,  0,   0,  32'h000,     32'h040,     0,  0);
    vecs[9]  = mk(0, 32'h0,       0,  1,   1,  32'h040,     32'h044,     0,  0);
    vecs[10] = mk(1, 32'h3FE,     0,  1,   0,  32'h000,     32'h3FC,     0,  1);
    vecs[11] = mk(0, 32'h0,       0,  1,   1,  32'h3FC,     32'h000,     0,  1);
    vecs[12] = mk(0, 32'h0,       0,  1,   1,  32'h000,     32'h004,     0,  1);
    vecs[13] = mk(0, 32'h0,       0,  0,   1,  32'h000,     32'h008,     0,  1);
    vecs[14] = mk(0, 32'h0,       1,  1,   1,  32'h004,     32'h008,     0,  1);
    vecs[15] = mk(0, 32'h0,       1,  1,   0,  32'h000,     32'h008,     1,  1);
    vecs[16] = mk(0, 32'h0,       1,  1,   0,  32'h000,     32'h008,     1,  1);
    vecs[17] = mk(1, 32'h101,     1,  1,   0,  32'h000,     32'h100,     1,  1);
    vecs[18] = mk(0, 32'h0,       0,  1,   1,  32'h100,     32'h104,     0,  1);
    vecs[19] = mk(1, 32'h20,      0,  1,   0,  32'h000,     32'h020,     0,  0);
    vecs[20] = mk(0, 32'h0,       0,  1,   1,  32'h020,     32'h024,     0,  0);

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_req       = 1'b0;
    out_ready      = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  {31'b0, out_valid}, 32'h0);
    chk("rst_addr",   imem_addr, 32'h0);
    chk("rst_pc",     out_pc, 32'h0);
    chk("rst_instr",  out_instr, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_mis",    {31'b0, redirect_misaligned}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if (i > 0) @(negedge clk);
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      halt_req       = vecs[i].halt;
      out_ready      = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].eaddr);
      chk($sformatf("v%0d_halted", i), {31'b0, halted}, {31'b0, vecs[i].eh});
      chk($sformatf("v%0d_mis", i), {31'b0, redirect_misaligned}, {31'b0, vecs[i].em});
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_pc", i), out_pc, vecs[i].epc);
        chk($sformatf("v%0d_instr", i), out_instr, rom(vecs[i].epc));
      end
    end

`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd12);
    chk("perf_flushed", perf_flushed, 32'd2);
`else
    chk("perf_fetched", perf_fetched, 32'd0);
    chk("perf_flushed", perf_flushed, 32'd0);
`endif

    // Asynchronous reset between clock edges with entries queued.
    @(negedge clk);
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    out_ready      = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_addr",  imem_addr, 32'h0);
    chk("arst_pc",    out_pc, 32'h0);
    chk("arst_perf",  perf_fetched, 32'h0);

    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_valid", {31'b0, out_valid}, 32'h1);
    chk("rst2_pc",    out_pc, 32'h0);
    chk("rst2_instr", out_instr, 32'h0000_0013);
    chk("rst2_addr",  imem_addr, 32'h4);
    @(posedge clk);
    #1;
    chk("rst3_pc",    out_pc, 32'h4);
    chk("rst3_instr", out_instr, 32'h0010_0093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Sequences the combinational byte-addressable instruction ROM (`memory`) for the IF stage. Owns the fetch PC and drives the ROM address. Captures each returned word together with its PC into a small prefetch FIFO, and hands entries to IF/ID through a valid/ready handshake. Handles branch/jump redirects (flush), a halt request, and PC wrap-around at ROM size.

Parameters:
- DEPTH_BYTES, 1024, ROM size in bytes; power of two, ≥8
- RESET_PC, 32'h0000_0000, fetch address after reset; word-aligned, < DEPTH_BYTES
- FIFO_DEPTH, 2, prefetch entries; power of two, ≥2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  32  byte address to ROM `addr`
- imem_instr  in  32  ROM `instr`, valid same cycle
- redirect_valid  in  1  single-cycle redirect strobe from EX
- redirect_pc  in  32  redirect target
- halt_req  in  1  level; while high no new fetches
- out_valid  out  1  FIFO head valid
- out_ready  in  1  IF/ID accepts head
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- halted  out  1  halt_req high and FIFO empty
- redirect_misaligned  out  1  registered; last redirect_pc[1:0]≠0

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; FIFO count/pointers=0; all entries 0.
  - out_valid=0, out_instr=0, out_pc=0, halted=0, redirect_misaligned=0.
- imem_addr = pc (combinational from the pc register); imem_instr is sampled in the same cycle.
- Push condition per cycle: !redirect_valid && !halt_req && (count<FIFO_DEPTH || pop).
  - pop = out_valid && out_ready.
  - On push, the entry {pc, imem_instr} is written at the tail, and pc <= (pc+4) & (DEPTH_BYTES-1).
  - From DEPTH_BYTES-4, pc wraps to 0.
- No push: pc holds.
- Latency: the first push occurs in the first clock after rst_n deasserts. out_valid rises one cycle after a push into an empty FIFO. There is no combinational fall-through.
- Full and popping in the same cycle: push and pop both occur; count unchanged. Sustains 1 instr/cycle.
- Empty: pop is ignored; out_instr/out_pc show the stale head storage and must be qualified by out_valid.
- Redirect has priority over push and pop:
  - FIFO is flushed (count=0, pointers=0); out_valid=0 next cycle; no push that cycle.
  - pc <= {redirect_pc[31:2],2'b00} & (DEPTH_BYTES-1).
  - redirect_misaligned <= |redirect_pc[1:0]; holds until the next redirect.
  - An entry handshaken (pop) in the redirect cycle counts as consumed; the downstream stage squashes it itself.
- Redirect timing: redirect in cycle N → target fetched in N+1 → out_valid=1 in N+2 (unless halt_req is high).
- Halt:
  - halt_req stops pushes only; the FIFO keeps draining.
  - halted = halt_req && count==0, registered (reflects end-of-cycle state).
  - A redirect during halt updates pc and flushes.
  - When halt_req falls, fetching resumes at pc in the next cycle.
- Reset mid-operation: immediate return to reset values; in-flight entries are lost.
- count width is clog2(FIFO_DEPTH)+1; pointers are clog2(FIFO_DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds ports `perf_fetched` (out, 32) and `perf_flushed` (out, 32).
  - perf_fetched increments on every push.
  - perf_flushed adds count-minus-pop (the valid entries discarded) on each redirect.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, the ports exist but are tied to 0 and no counter logic is built.

Test Plan:
- Reset release, ROM words 0x00000013/0x00100093/0x00200113 at 0/4/8, out_ready=1 → out_valid rises 2nd cycle after rst_n↑; out_pc 0,4,8 on consecutive cycles with matching instrs.
- out_ready=0 for 6 cycles → FIFO fills to 2, imem_addr holds at 8, out_pc stays 0; ready↑ → 0,4,8 in order, no duplicate or skip.
- Redirect to 0x40 while FIFO full → out_valid=0 next cycle, out_pc=0x40 two cycles after redirect; perf_flushed=2 with FETCH_PERF_EN.
- Redirect to 0x3FE (DEPTH_BYTES=1024) → redirect_misaligned=1, out_pc=0x3FC then 0x000 (wrap).
- halt_req=1 with 2 entries queued, out_ready=1 → 2 pops, halted=1 on the following cycle, imem_addr frozen; halt_req=0 → fetch resumes at the frozen address.
- rst_n pulsed low mid-stream → out_valid=0 and imem_addr=RESET_PC immediately (asynchronous); normal restart afterwards.
